// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage_pkg
//  Description : Shared constants and types for the instruction-fetch stage
//                and its IF/ID pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_stage_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;  // only after reset
  localparam fetch_state_t ST_REQ  = 2'd1;  // request to imem at pc
  localparam fetch_state_t ST_HOLD = 2'd2;  // response parked while ID stalls
  localparam fetch_state_t ST_DROP = 2'd3;  // waiting to discard a stale response

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage_ifid_reg
//  Description : IF/ID pipeline register. Kill (flush) beats load, load beats
//                bubble; with no control asserted the contents are held.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage_ifid_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill_i,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  // Select the next register contents from the kill/load/bubble controls.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (kill_i) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end else if (bubble_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // Register state, cleared to an empty NOP slot on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage
//  Description : Instruction-fetch stage. Owns the PC, keeps exactly one
//                request outstanding to instruction memory, and feeds the
//                IF/ID register. Handles load-use stall and branch flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            imem_valid_i,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [31:0]     ifid_instr_o,
  output logic            ifid_valid_o,
  output logic            fetch_busy_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;   // address of the request on the bus
  logic            req_q, req_d;
  logic [31:0]     buf_q, buf_d;     // response parked during a stall

  logic            ifid_kill, ifid_load, ifid_bubble;
  logic [31:0]     ifid_instr_in;
  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] pc_plus4;

  assign target_aligned = branch_target_i & ~XLEN'(3);
  assign pc_plus4       = pc_q + XLEN'(4);

  // Fetch FSM: next state, PC, hold buffer and IF/ID controls.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    ifid_kill     = 1'b0;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    ifid_instr_in = imem_rdata_i;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (flush_i) begin
          pc_d      = target_aligned;
          ifid_kill = 1'b1;
        end
      end
      ST_REQ: begin
        if (flush_i) begin
          // A response arriving with the flush closes the old request, so a
          // new one can go straight out; otherwise wait to discard it.
          pc_d      = target_aligned;
          ifid_kill = 1'b1;
          state_d   = imem_valid_i ? ST_REQ : ST_DROP;
        end else if (imem_valid_i && stall_i) begin
          buf_d   = imem_rdata_i;
          state_d = ST_HOLD;
        end else if (imem_valid_i) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
        end else if (!stall_i) begin
          ifid_bubble = 1'b1;
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          pc_d      = target_aligned;
          ifid_kill = 1'b1;
          state_d   = ST_REQ;
        end else if (!stall_i) begin
          ifid_load     = 1'b1;
          ifid_instr_in = buf_q;
          pc_d          = pc_plus4;
          state_d       = ST_REQ;
        end
      end
      ST_DROP: begin
        if (flush_i) begin
          pc_d      = target_aligned;
          ifid_kill = 1'b1;
        end else if (!stall_i) begin
          ifid_bubble = 1'b1;
        end
        // The stale response ends the old request; a flush arriving with it
        // has already retargeted pc, so the new request uses that.
        if (imem_valid_i) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request/address outputs follow the next state; DROP keeps the old address.
  always_comb begin
    req_d  = (state_d == ST_REQ) || (state_d == ST_DROP);
    addr_d = (state_d == ST_REQ) ? pc_d : addr_q;
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      buf_q   <= buf_d;
    end
  end

  if_fetch_stage_ifid_reg #(
    .XLEN (XLEN)
  ) u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .kill_i   (ifid_kill),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .pc_i     (pc_q),
    .instr_i  (ifid_instr_in),
    .pc_o     (ifid_pc_o),
    .instr_o  (ifid_instr_o),
    .valid_o  (ifid_valid_o)
  );

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign fetch_busy_o = ((state_q == ST_REQ) && !imem_valid_i) || (state_q == ST_DROP);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_stage
//  Description : Directed vector bench for if_fetch_stage (two instances:
//                default reset PC and a reset PC near the top of memory).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;

  // Instance A: RESET_PC = 0
  logic        rst_n, stall, flush, valid;
  logic [31:0] tgt, rdata;
  logic        req, ifvalid, busy;
  logic [31:0] addr, ifpc, ifinstr;

  // Instance B: RESET_PC = 0xFFFF_FFF8
  logic        rst2_n, stall2, flush2, valid2;
  logic [31:0] tgt2, rdata2;
  logic        req2, ifvalid2, busy2;
  logic [31:0] addr2, ifpc2, ifinstr2;

  int n_vec  = 0;
  int n_fail = 0;

  if_fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall),
    .flush_i         (flush),
    .branch_target_i (tgt),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_rdata_i    (rdata),
    .imem_valid_i    (valid),
    .ifid_pc_o       (ifpc),
    .ifid_instr_o    (ifinstr),
    .ifid_valid_o    (ifvalid),
    .fetch_busy_o    (busy)
  );

  if_fetch_stage #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut2 (
    .clk             (clk),
    .rst_n           (rst2_n),
    .stall_i         (stall2),
    .flush_i         (flush2),
    .branch_target_i (tgt2),
    .imem_req_o      (req2),
    .imem_addr_o     (addr2),
    .imem_rdata_i    (rdata2),
    .imem_valid_i    (valid2),
    .ifid_pc_o       (ifpc2),
    .ifid_instr_o    (ifinstr2),
    .ifid_valid_o    (ifvalid2),
    .fetch_busy_o    (busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall, flush;
    logic [31:0] tgt;
    logic        valid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr, ifpc, ifinstr;
    logic        ifvalid, busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic s, logic f, logic [31:0] t, logic v, logic [31:0] d,
                              logic rq, logic [31:0] a, logic [31:0] p, logic [31:0] i,
                              logic iv, logic b);
    vec_t r;
    r.stall = s; r.flush = f; r.tgt = t; r.valid = v; r.rdata = d;
    r.req = rq; r.addr = a; r.ifpc = p; r.ifinstr = i; r.ifvalid = iv; r.busy = b;
    return r;
  endfunction

  task automatic cmp(string tag, int idx, string sig, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] %s: got %h, expected %h", tag, idx, sig, act, exp);
    end
  endtask

  task automatic check_a(string tag, int idx, logic rq, logic [31:0] a, logic [31:0] p,
                         logic [31:0] i, logic iv, logic b);
    n_vec++;
    cmp(tag, idx, "req",   32'(req),     32'(rq));
    cmp(tag, idx, "addr",  addr,         a);
    cmp(tag, idx, "ifpc",  ifpc,         p);
    cmp(tag, idx, "instr", ifinstr,      i);
    cmp(tag, idx, "valid", 32'(ifvalid), 32'(iv));
    cmp(tag, idx, "busy",  32'(busy),    32'(b));
  endtask

  task automatic check_b(string tag, int idx, logic rq, logic [31:0] a, logic [31:0] p,
                         logic [31:0] i, logic iv, logic b);
    n_vec++;
    cmp(tag, idx, "req",   32'(req2),     32'(rq));
    cmp(tag, idx, "addr",  addr2,         a);
    cmp(tag, idx, "ifpc",  ifpc2,         p);
    cmp(tag, idx, "instr", ifinstr2,      i);
    cmp(tag, idx, "valid", 32'(ifvalid2), 32'(iv));
    cmp(tag, idx, "busy",  32'(busy2),    32'(b));
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0; valid = 0; tgt = '0; rdata = '0;
    rst2_n = 1'b0; stall2 = 0; flush2 = 0; valid2 = 0; tgt2 = '0; rdata2 = '0;

    //       stall flush tgt    valid rdata          req addr     ifpc    ifinstr        iv busy
    tv.push_back(mk(0,0,32'h0,  0,32'h0,          0,32'h0,  32'h0,  NOP,          0,0)); // IDLE
    tv.push_back(mk(0,0,32'h0,  1,32'hA000_0000,  1,32'h0,  32'h0,  NOP,          0,0)); // 1-cycle mem
    tv.push_back(mk(0,0,32'h0,  1,32'hA000_0004,  1,32'h4,  32'h0,  32'hA000_0000,1,0));
    tv.push_back(mk(0,0,32'h0,  1,32'hA000_0008,  1,32'h8,  32'h4,  32'hA000_0004,1,0));
    tv.push_back(mk(0,0,32'h0,  1,32'hA000_000C,  1,32'hC,  32'h8,  32'hA000_0008,1,0));
    tv.push_back(mk(0,0,32'h0,  0,32'h0,          1,32'h10, 32'hC,  32'hA000_000C,1,1)); // 3-cycle mem
    tv.push_back(mk(0,0,32'h0,  0,32'h0,          1,32'h10, 32'hC,  NOP,          0,1));
    tv.push_back(mk(0,0,32'h0,  1,32'hA000_0010,  1,32'h10, 32'hC,  NOP,          0,0));
    tv.push_back(mk(0,0,32'h0,  0,32'h0,          1,32'h14, 32'h10, 32'hA000_0010,1,1));
    tv.push_back(mk(0,0,32'h0,  0,32'h0,          1,32'h14, 32'h10, NOP,          0,1));
    tv.push_back(mk(0,0,32'h0,  1,32'hA000_0014,  1,32'h14, 32'h10, NOP,          0,0));
    tv.push_back(mk(1,0,32'h0,  1,32'hA000_0018,  1,32'h18, 32'h14, 32'hA000_0014,1,0)); // -> HOLD
    tv.push_back(mk(1,0,32'h0,  0,32'h0,          0,32'h18, 32'h14, 32'hA000_0014,1,0));
    tv.push_back(mk(1,0,32'h0,  0,32'h0,          0,32'h18, 32'h14, 32'hA000_0014,1,0));
    tv.push_back(mk(0,0,32'h0,  0,32'h0,          0,32'h18, 32'h14, 32'hA000_0014,1,0)); // release
    tv.push_back(mk(0,0,32'h0,  1,32'hA000_001C,  1,32'h1C, 32'h18, 32'hA000_0018,1,0));
    tv.push_back(mk(0,1,32'h100,0,32'h0,          1,32'h20, 32'h1C, 32'hA000_001C,1,1)); // -> DROP
    tv.push_back(mk(0,0,32'h0,  0,32'h0,          1,32'h20, 32'h0,  NOP,          0,1));
    tv.push_back(mk(0,0,32'h0,  1,32'hDEAD_BEEF,  1,32'h20, 32'h0,  NOP,          0,1)); // stale
    tv.push_back(mk(0,0,32'h0,  1,32'hB000_0100,  1,32'h100,32'h0,  NOP,          0,0));
    tv.push_back(mk(1,0,32'h0,  1,32'hB000_0104,  1,32'h104,32'h100,32'hB000_0100,1,0)); // -> HOLD
    tv.push_back(mk(1,1,32'h203,0,32'h0,          0,32'h104,32'h100,32'hB000_0100,1,0)); // flush+stall
    tv.push_back(mk(1,0,32'h0,  0,32'h0,          1,32'h200,32'h0,  NOP,          0,1));
    tv.push_back(mk(0,1,32'h40, 1,32'hC000_0200,  1,32'h200,32'h0,  NOP,          0,0)); // flush+valid
    tv.push_back(mk(0,0,32'h0,  1,32'hC000_0040,  1,32'h40, 32'h0,  NOP,          0,0));
    tv.push_back(mk(1,0,32'h0,  0,32'h0,          1,32'h44, 32'h40, 32'hC000_0040,1,1)); // stall, no rsp
    tv.push_back(mk(0,1,32'h80, 0,32'h0,          1,32'h44, 32'h40, 32'hC000_0040,1,1)); // -> DROP
    tv.push_back(mk(0,1,32'h90, 0,32'h0,          1,32'h44, 32'h0,  NOP,          0,1)); // re-flush
    tv.push_back(mk(0,0,32'h0,  1,32'hDEAD_BEEF,  1,32'h44, 32'h0,  NOP,          0,1));
    tv.push_back(mk(0,0,32'h0,  1,32'hC000_0090,  1,32'h90, 32'h0,  NOP,          0,0));
    tv.push_back(mk(0,0,32'h0,  0,32'h0,          1,32'h94, 32'h90, 32'hC000_0090,1,1));

    // Reset state of instance A.
    repeat (2) @(negedge clk);
    #1;
    check_a("reset", 0, 0, 32'h0, 32'h0, NOP, 0, 0);

    foreach (tv[i]) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      stall = tv[i].stall; flush = tv[i].flush; tgt = tv[i].tgt;
      valid = tv[i].valid; rdata = tv[i].rdata;
      #1;
      check_a("vec", i, tv[i].req, tv[i].addr, tv[i].ifpc, tv[i].ifinstr,
              tv[i].ifvalid, tv[i].busy);
    end
    @(negedge clk);
    stall = 0; flush = 0; valid = 0;

    // Instance B: PC wrap-around, async reset mid-request, flush in IDLE.
    @(negedge clk); rst2_n = 1'b1; valid2 = 0; #1;
    check_b("wrap", 0, 0, 32'hFFFF_FFF8, 32'h0, NOP, 0, 0);
    @(negedge clk); valid2 = 1; rdata2 = 32'h1111_1111; #1;
    check_b("wrap", 1, 1, 32'hFFFF_FFF8, 32'h0, NOP, 0, 0);
    @(negedge clk); rdata2 = 32'h2222_2222; #1;
    check_b("wrap", 2, 1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h1111_1111, 1, 0);
    @(negedge clk); rdata2 = 32'h3333_3333; #1;
    check_b("wrap", 3, 1, 32'h0, 32'hFFFF_FFFC, 32'h2222_2222, 1, 0);
    @(negedge clk); valid2 = 0; #1;
    check_b("wrap", 4, 1, 32'h4, 32'h0, 32'h3333_3333, 1, 1);
    #1 rst2_n = 1'b0;
    #1;
    check_b("async_rst", 0, 0, 32'hFFFF_FFF8, 32'h0, NOP, 0, 0);
    @(negedge clk); rst2_n = 1'b1; flush2 = 1; tgt2 = 32'h33; #1;
    check_b("idle_flush", 0, 0, 32'hFFFF_FFF8, 32'h0, NOP, 0, 0);
    @(negedge clk); flush2 = 0; #1;
    check_b("idle_flush", 1, 1, 32'h30, 32'h0, NOP, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RISC-V core.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Presents fetched instructions to ID.
- Consumes the load-use stall from the hazard detection unit (freezes PC and IF/ID) and the branch flush from EX (redirects PC, injects NOP bubble).

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded at reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hazard-unit stall; hold PC and IF/ID contents
flush_i  in  1  taken branch/jump resolved in EX; redirect and kill
branch_target_i  in  XLEN  redirect PC, valid when flush_i=1
imem_req_o  out  1  fetch request to instruction memory
imem_addr_o  out  XLEN  fetch address; stable while imem_req_o=1 and no imem_valid_i
imem_rdata_i  in  32  instruction word, valid with imem_valid_i
imem_valid_i  in  1  response strobe; one per request; 1..N cycles latency
ifid_pc_o  out  XLEN  PC of instruction in IF/ID
ifid_instr_o  out  32  instruction in IF/ID
ifid_valid_o  out  1  IF/ID holds a real instruction, not a bubble
fetch_busy_o  out  1  request outstanding or discard pending

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE, imem_req_o=0.
  - ifid_pc_o=0, ifid_instr_o=32'h0000_0013 (NOP), ifid_valid_o=0, fetch_busy_o=0.
  - Reset mid-request: the response is never consumed; memory is expected to be reset together with the core.
- States: IDLE, REQ, HOLD, DROP. Outputs are registered. imem_addr_o=pc in REQ; in DROP it holds the old address.
- IDLE:
  - Entered only from reset.
  - Next cycle goes to REQ with imem_req_o=1.
  - A flush in IDLE loads pc=target and goes to REQ.
- REQ, imem_req_o=1; priority is flush > valid&stall > valid > none:
  - flush_i & imem_valid_i: drop the data, pc<=target, stay in REQ.
  - flush_i & !imem_valid_i: pc<=target, go to DROP.
  - imem_valid_i & stall_i: capture rdata into the hold buffer, pc unchanged, imem_req_o<=0, go to HOLD. IF/ID is unchanged.
  - imem_valid_i & !stall_i: IF/ID<={pc,rdata,1}, pc<=pc+4, stay in REQ; the next request issues back-to-back.
  - No valid & !stall_i: ifid_valid_o<=0 and ifid_instr_o<=NOP (bubble). No valid & stall_i: IF/ID held.
- HOLD, imem_req_o=0:
  - flush_i: discard the buffer, pc<=target, go to REQ.
  - !stall_i: IF/ID<={pc,buffer,1}, pc<=pc+4, go to REQ.
  - Otherwise hold.
- DROP, imem_req_o=1 at the old address:
  - On imem_valid_i, discard the data and go to REQ at the new pc.
  - A further flush in DROP overwrites pc and stays in DROP.
- flush_i always writes IF/ID with {pc=0, NOP, valid=0}, even if stall_i=1. Flush beats stall.
- Arithmetic and alignment:
  - pc+4 wraps modulo 2^XLEN; 32'hFFFF_FFFC+4 gives 0.
  - branch_target_i[1:0] is forced to 0.
- fetch_busy_o = (state==REQ & !imem_valid_i) | state==DROP.
- Exactly one request is outstanding at any time. No response is ever reordered or delivered twice.

Decomposition:
- Shared package: XLEN default, NOP_INSTR=32'h0000_0013, fetch state enum {IDLE, REQ, HOLD, DROP}.
- Sub-module ifid_reg: the IF/ID register with load/hold/bubble controls, reused in pattern for the ID/EX register.

Test Plan:
- Reset release, memory with 1-cycle latency and stall_i=0 -> addresses 0,4,8,12 issue back-to-back; ifid_valid_o=1 from cycle 3; ifid_pc_o tracks each address.
- Memory with 3-cycle latency -> two bubble cycles (valid=0, instr=0x13) between each real instruction; imem_addr_o stable throughout.
- stall_i high for 3 cycles as the response for PC=8 arrives -> HOLD entered, imem_req_o=0, IF/ID holds PC=4; on release IF/ID shows PC=8 with the correct word, then address 12 issues.
- flush_i with target=0x100 while a request to 0x10 is outstanding -> DROP; the 0x10 data is never visible in IF/ID; the next request is 0x100; IF/ID is a bubble meanwhile.
- flush_i and stall_i together in HOLD, target=0x203 -> buffer discarded, request goes to 0x200, IF/ID={0,NOP,0}.
- RESET_PC=0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst_n asserted mid-request -> all outputs return to reset values asynchronously.
